// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the multicycle datapath control unit.
package mem_ctrl_pkg;

  // Control sequencer states; the encoding is also visible on DbgState.
  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_FETCH_ADDR = 4'd1,
    ST_FETCH_WAIT = 4'd2,
    ST_FETCH_IR   = 4'd3,
    ST_DECODE     = 4'd4,
    ST_EXEC_ALU   = 4'd5,
    ST_MEM_ADDR   = 4'd6,
    ST_LOAD_WAIT  = 4'd7,
    ST_LOAD_WB    = 4'd8,
    ST_STORE_DATA = 4'd9,
    ST_STORE_WAIT = 4'd10,
    ST_HALTED     = 4'd11,
    ST_FAULT      = 4'd12
  } state_t;

  // Decoded instruction classes presented on OpClass.
  localparam logic [1:0] OP_ALU   = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;
  localparam logic [1:0] OP_HALT  = 2'b11;

  // Memory direction on RW.
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/mac_wait_timer.sv
// Wait-cycle counter: cleared outside wait states, counts each wait cycle and
// flags the last permitted wait cycle.
module mac_wait_timer #(
  parameter int TIMEOUT = 16,
  parameter int CW      = 5
) (
  input  logic CLK,
  input  logic RST,
  input  logic Clr,
  input  logic En,
  output logic Expired
);

  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  // Count wait cycles; saturate at the last cycle so the counter never wraps.
  always_ff @(posedge CLK) begin
    if (RST || Clr) begin
      count <= '0;
    end else if (En && (count != LAST)) begin
      count <= count + 1'b1;
    end
  end

  // High during the TIMEOUT-th cycle of a wait.
  assign Expired = (count == LAST);

endmodule

// File: rtl/mem_access_ctrl.sv
// Moore control sequencer for fetch / ALU / load / store / halt flows with a
// bounded memory handshake.
// Handshake: MOV is held high for the whole wait state; the memory completes
// by raising MOC, which is only sampled while MOV=1, and MOV drops on the
// cycle after MOC is seen high. A wait lasting TIMEOUT cycles without MOC
// ends in FAULT.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CW      = 5
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] OpClass,
  input  logic       SetFlags,
  input  logic       MOC,
  output logic       IRLd,
  output logic       MARLd,
  output logic       MDRLd,
  output logic       FDRLd,
  output logic       MARSel,
  output logic       MDRSel,
  output logic       MOV,
  output logic       RW,
  output logic       PCInc,
  output logic       RFLd,
  output logic       MemErr,
  output logic       Halted,
  output logic [3:0] DbgState
);

  state_t     state, state_nxt;
  logic [1:0] op_q;
  logic       flag_q;
  logic       in_wait;
  logic       expired;
  logic       timeout;

  assign in_wait  = (state == ST_FETCH_WAIT) || (state == ST_LOAD_WAIT) ||
                    (state == ST_STORE_WAIT);
  assign timeout  = in_wait && expired && !MOC;
  assign DbgState = state;

  mac_wait_timer #(
    .TIMEOUT (TIMEOUT),
    .CW      (CW)
  ) u_timer (
    .CLK     (CLK),
    .RST     (RST),
    .Clr     (!in_wait),
    .En      (in_wait),
    .Expired (expired)
  );

  // State register plus op class / SetFlags captured in DECODE for the flow.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= ST_IDLE;
      op_q   <= OP_ALU;
      flag_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_DECODE) begin
        op_q   <= OpClass;
        flag_q <= SetFlags;
      end
    end
  end

  // Next-state selection; MOC takes priority over timeout in wait states.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:       state_nxt = ST_FETCH_ADDR;
      ST_FETCH_ADDR: state_nxt = ST_FETCH_WAIT;
      ST_FETCH_WAIT: begin
        if (MOC)          state_nxt = ST_FETCH_IR;
        else if (timeout) state_nxt = ST_FAULT;
      end
      ST_FETCH_IR:   state_nxt = ST_DECODE;
      ST_DECODE: begin
        case (OpClass)
          OP_ALU:  state_nxt = ST_EXEC_ALU;
          OP_HALT: state_nxt = ST_HALTED;
          default: state_nxt = ST_MEM_ADDR;
        endcase
      end
      ST_EXEC_ALU:   state_nxt = ST_FETCH_ADDR;
      ST_MEM_ADDR:   state_nxt = (op_q == OP_LOAD) ? ST_LOAD_WAIT : ST_STORE_DATA;
      ST_LOAD_WAIT: begin
        if (MOC)          state_nxt = ST_LOAD_WB;
        else if (timeout) state_nxt = ST_FAULT;
      end
      ST_LOAD_WB:    state_nxt = ST_FETCH_ADDR;
      ST_STORE_DATA: state_nxt = ST_STORE_WAIT;
      ST_STORE_WAIT: begin
        if (MOC)          state_nxt = ST_FETCH_ADDR;
        else if (timeout) state_nxt = ST_FAULT;
      end
      ST_HALTED:     state_nxt = ST_HALTED;
      ST_FAULT:      state_nxt = ST_FAULT;
      default:       state_nxt = ST_IDLE;
    endcase
  end

  // Output decode from state; only MDRLd in read waits follows MOC.
  always_comb begin
    IRLd   = 1'b0;
    MARLd  = 1'b0;
    MDRLd  = 1'b0;
    FDRLd  = 1'b0;
    MARSel = 1'b0;
    MDRSel = 1'b0;
    MOV    = 1'b0;
    RW     = RW_WRITE;
    PCInc  = 1'b0;
    RFLd   = 1'b0;
    MemErr = 1'b0;
    Halted = 1'b0;
    case (state)
      ST_FETCH_ADDR: MARLd = 1'b1;
      ST_FETCH_WAIT, ST_LOAD_WAIT: begin
        MOV   = 1'b1;
        RW    = RW_READ;
        MDRLd = MOC;
      end
      ST_FETCH_IR: begin
        IRLd  = 1'b1;
        PCInc = 1'b1;
      end
      ST_EXEC_ALU: begin
        RFLd  = 1'b1;
        FDRLd = flag_q;
      end
      ST_MEM_ADDR: begin
        MARLd  = 1'b1;
        MARSel = 1'b1;
      end
      ST_LOAD_WB:    RFLd = 1'b1;
      ST_STORE_DATA: begin
        MDRLd  = 1'b1;
        MDRSel = 1'b1;
      end
      ST_STORE_WAIT: MOV = 1'b1;
      ST_HALTED:     Halted = 1'b1;
      ST_FAULT:      MemErr = 1'b1;
      default:       ;
    endcase
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: each driven cycle queues the outputs
// expected during that cycle; a negedge monitor pops and compares.
module tb_mem_access_ctrl;
  import mem_ctrl_pkg::*;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [1:0] OpClass = 2'b00;
  logic       SetFlags = 1'b0;
  logic       MOC = 1'b0;
  logic       IRLd, MARLd, MDRLd, FDRLd, MARSel, MDRSel, MOV, RW;
  logic       PCInc, RFLd, MemErr, Halted;
  logic [3:0] DbgState;

  logic [15:0] exp_q[$];
  string       tag_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic        exp_flag = 1'b0;

  mem_access_ctrl #(.TIMEOUT(16), .CW(5)) dut (
    .CLK(CLK), .RST(RST), .OpClass(OpClass), .SetFlags(SetFlags), .MOC(MOC),
    .IRLd(IRLd), .MARLd(MARLd), .MDRLd(MDRLd), .FDRLd(FDRLd),
    .MARSel(MARSel), .MDRSel(MDRSel), .MOV(MOV), .RW(RW), .PCInc(PCInc),
    .RFLd(RFLd), .MemErr(MemErr), .Halted(Halted), .DbgState(DbgState)
  );

  // Clock / reset block: 10 ns period.
  always #5 CLK = ~CLK;

  // Expected output vector {state, IRLd, MARLd, MDRLd, FDRLd, MARSel, MDRSel,
  // MOV, RW, PCInc, RFLd, MemErr, Halted} for a cycle spent in state s.
  function automatic logic [15:0] exp_vec(input state_t s, input logic moc, input logic fl);
    logic [3:0] sv;
    logic ir, mar, mdr, fdr, marsel, mdrsel, mov, rw, pci, rfl, err, hlt;
    sv = s;
    {ir, mar, mdr, fdr, marsel, mdrsel, mov, rw, pci, rfl, err, hlt} = '0;
    case (s)
      ST_FETCH_ADDR: mar = 1'b1;
      ST_FETCH_WAIT, ST_LOAD_WAIT: begin mov = 1'b1; rw = 1'b1; mdr = moc; end
      ST_FETCH_IR:   begin ir = 1'b1; pci = 1'b1; end
      ST_EXEC_ALU:   begin rfl = 1'b1; fdr = fl; end
      ST_MEM_ADDR:   begin mar = 1'b1; marsel = 1'b1; end
      ST_LOAD_WB:    rfl = 1'b1;
      ST_STORE_DATA: begin mdr = 1'b1; mdrsel = 1'b1; end
      ST_STORE_WAIT: mov = 1'b1;
      ST_HALTED:     hlt = 1'b1;
      ST_FAULT:      err = 1'b1;
      default:       ;
    endcase
    return {sv, ir, mar, mdr, fdr, marsel, mdrsel, mov, rw, pci, rfl, err, hlt};
  endfunction

  // Driver: apply inputs for one cycle in which the DUT should sit in state s.
  task automatic step(input state_t s, input logic moc, input logic [1:0] opc,
                      input logic sf, input logic rst, input string tag);
    RST = rst; MOC = moc; OpClass = opc; SetFlags = sf;
    exp_q.push_back(exp_vec(s, moc, exp_flag));
    tag_q.push_back(tag);
    if (rst) exp_flag = 1'b0;
    else if (s == ST_DECODE) exp_flag = sf;
    @(posedge CLK); #1;
  endtask

  // Cycle where OpClass / SetFlags are don't-care and must be ignored.
  task automatic s(input state_t st, input logic moc, input string tag);
    step(st, moc, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0, tag);
  endtask

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  // Fetch with MOC on wait cycle k, then DECODE presenting opc/sf.
  task automatic fetch(input int k, input logic [1:0] opc, input logic sf, input string tag);
    s(ST_FETCH_ADDR, rnd(), {tag, "_fa"});
    for (int i = 0; i < k - 1; i++) s(ST_FETCH_WAIT, 1'b0, {tag, "_fw"});
    s(ST_FETCH_WAIT, 1'b1, {tag, "_fw_moc"});
    s(ST_FETCH_IR, rnd(), {tag, "_fir"});
    step(ST_DECODE, rnd(), opc, sf, 1'b0, {tag, "_dec"});
  endtask

  // Scoreboard monitor: compare away from the active edge.
  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      logic [15:0] got, exp;
      string tag;
      got = {DbgState, IRLd, MARLd, MDRLd, FDRLd, MARSel, MDRSel, MOV, RW,
             PCInc, RFLd, MemErr, Halted};
      exp = exp_q.pop_front();
      tag = tag_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
    end
  end

  initial begin
    repeat (2) @(posedge CLK);
    #1;
    // Reset state: outputs all 0 while held in reset and right after.
    step(ST_IDLE, 1'b1, 2'b11, 1'b1, 1'b1, "rst_hold");
    step(ST_IDLE, rnd(), 2'b00, 1'b0, 1'b0, "idle");

    // ALU, SetFlags=1, MOC on first wait cycle; next fetch at cycle 6.
    fetch(1, OP_ALU, 1'b1, "alu1");
    s(ST_EXEC_ALU, rnd(), "alu1_exec");

    // LOAD with MOC on third load-wait cycle.
    fetch(1, OP_LOAD, rnd(), "ld");
    s(ST_MEM_ADDR, rnd(), "ld_ma");
    s(ST_LOAD_WAIT, 1'b0, "ld_w1");
    s(ST_LOAD_WAIT, 1'b0, "ld_w2");
    s(ST_LOAD_WAIT, 1'b1, "ld_w3_moc");
    s(ST_LOAD_WB, rnd(), "ld_wb");

    // STORE with MOC on second store-wait cycle.
    fetch(2, OP_STORE, rnd(), "st");
    s(ST_MEM_ADDR, rnd(), "st_ma");
    s(ST_STORE_DATA, rnd(), "st_data");
    s(ST_STORE_WAIT, 1'b0, "st_w1");
    s(ST_STORE_WAIT, 1'b1, "st_w2_moc");

    // MOC on the 16th fetch wait cycle: normal completion; ALU without flags.
    fetch(16, OP_ALU, 1'b0, "edge16");
    s(ST_EXEC_ALU, rnd(), "edge16_exec");

    // MOC never arrives: FAULT after 16 wait cycles, sticky until reset.
    s(ST_FETCH_ADDR, rnd(), "to_fa");
    for (int i = 0; i < 16; i++) s(ST_FETCH_WAIT, 1'b0, "to_fw");
    for (int i = 0; i < 3; i++) s(ST_FAULT, rnd(), "fault_hold");
    step(ST_FAULT, 1'b1, 2'b00, 1'b0, 1'b1, "fault_rst");
    step(ST_IDLE, rnd(), 2'b01, 1'b0, 1'b0, "fault_idle");

    // HALT: stays halted regardless of MOC / OpClass until reset.
    fetch(1, OP_HALT, rnd(), "halt");
    for (int i = 0; i < 4; i++) s(ST_HALTED, rnd(), "halt_hold");
    step(ST_HALTED, 1'b1, 2'b00, 1'b0, 1'b1, "halt_rst");
    step(ST_IDLE, rnd(), 2'b00, 1'b0, 1'b0, "halt_idle");

    // Reset in the middle of a load wait aborts immediately.
    fetch(1, OP_LOAD, rnd(), "ldr");
    s(ST_MEM_ADDR, rnd(), "ldr_ma");
    s(ST_LOAD_WAIT, 1'b0, "ldr_w1");
    step(ST_LOAD_WAIT, 1'b0, 2'b00, 1'b0, 1'b1, "ldr_rst");
    step(ST_IDLE, 1'b1, 2'b00, 1'b0, 1'b0, "ldr_idle");
    fetch(1, OP_ALU, 1'b1, "restart");
    s(ST_EXEC_ALU, rnd(), "restart_exec");
    s(ST_FETCH_ADDR, rnd(), "restart_fa");

    repeat (2) @(negedge CLK);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
